dct_transpose_buffer: RTL and testbench

Ping-pong 8x8 transpose memory between the row-pass and column-pass 1D DCT stages of the 2D DCT datapath. It accepts one 8-element row vector per handshake from the row-pass DCT output. After a full 8x8 block is written, it emits the same block as 8 column vectors to the column-pass DCT. Two banks let block N+1 be written while block N is read out.

---
 rtl/dct_pkg.sv | 10 +
 rtl/dct_tp_bank.sv | 42 ++++
 rtl/dct_transpose_buffer.sv | 82 ++++++++
 tb/tb_dct_transpose_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the 2D DCT datapath: transform size, default
// coefficient width and the row/column index type used by all stages.
package dct_pkg;

  localparam int DCT_N          = 8;
  localparam int DCT_DATA_WIDTH = 32;

  typedef logic [2:0] dct_idx_t;

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 transpose bank: whole rows are written in, whole columns are read
// out through a combinational mux. Contents are opaque bit patterns.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [2:0]                  wr_row,
  input  logic [DCT_N*DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]                  rd_col,
  output logic [DCT_N*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DCT_N][DCT_N];

  // Row write port; storage clears on reset so an idle output reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DCT_N; r++) begin
        for (int c = 0; c < DCT_N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < DCT_N; c++) begin
        mem[wr_row][c] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Column read mux: element i of the output is row i of the selected column
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DCT_N; i++) begin
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass DCT.
// Rows fill one bank while the other bank drains as columns; a per-bank full
// flag hands each block from the write side to the read side.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DCT_N*DATA_WIDTH-1:0] in_row,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DCT_N*DATA_WIDTH-1:0] out_col,
  output logic                        out_last
);

  logic [1:0] full;
  logic       wr_bank;
  dct_idx_t   wr_row;
  logic       rd_bank;
  dct_idx_t   rd_col;
  logic       wr_fire;
  logic       rd_fire;

  logic [DCT_N*DATA_WIDTH-1:0] col_data [2];

  assign in_ready  = !full[wr_bank];
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = full[rd_bank];
  assign rd_fire   = out_valid && out_ready;
  assign out_last  = out_valid && (rd_col == 3'd7);
  assign out_col   = col_data[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_fire && (wr_bank == b[0])),
      .wr_row  (wr_row),
      .wr_data (in_row),
      .rd_col  (rd_col),
      .rd_data (col_data[b])
    );
  end

  // Write pointer: advance per accepted row, hop to the other bank after row 7
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_row <= wr_row + 3'd1;
      if (wr_row == 3'd7) wr_bank <= !wr_bank;
    end
  end

  // Read pointer: advance per accepted column, hop to the other bank after column 7
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_col <= rd_col + 3'd1;
      if (rd_col == 3'd7) rd_bank <= !rd_bank;
    end
  end

  // Full flags: set on the last row written, cleared on the last column read.
  // A set and a clear in the same cycle always hit different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_fire && (wr_row == 3'd7)) full[wr_bank] <= 1'b1;
      if (rd_fire && (rd_col == 3'd7)) full[rd_bank] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Randomised bench for dct_transpose_buffer: a block-queue reference model
// predicts handshakes and transposed columns cycle by cycle; a second
// instance at DATA_WIDTH=16 checks bit-exact pass-through of edge values.
module tb_dct_transpose_buffer;

  localparam int W   = 32;
  localparam int W16 = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, out_valid, out_ready, out_last;
  logic [8*W-1:0] in_row, out_col;

  logic             in_valid16, in_ready16, out_valid16, out_ready16, out_last16;
  logic [8*W16-1:0] in_row16, out_col16;

  int n_total = 0;
  int n_pass  = 0;

  typedef logic [64*W-1:0] blk_t;
  blk_t           fullq[$];
  blk_t           part;
  int             part_rows;
  int             col_idx;
  logic [8*W-1:0] rowq[$];

  always #5 clk = ~clk;

  dct_transpose_buffer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last)
  );

  dct_transpose_buffer #(.DATA_WIDTH(W16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_row(in_row16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_col(out_col16), .out_last(out_last16)
  );

  task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    fullq.delete();
    rowq.delete();
    part      = '0;
    part_rows = 0;
    col_idx   = 0;
  endtask

  task automatic push_rand_rows(input int n);
    logic [8*W-1:0] r;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 8; c++) r[c*W +: W] = $urandom;
      rowq.push_back(r);
    end
  endtask

  // One clock: present stimulus, check outputs against the model at the
  // falling edge, then commit the predicted handshakes at the rising edge.
  task automatic cycle(input logic ordy, input int gap_pct);
    logic           iv, exp_ir, exp_ov, wr, rd;
    logic [8*W-1:0] e;
    iv = (rowq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    in_valid  = iv;
    in_row    = iv ? rowq[0] : {8{32'hDEAD_BEEF}};
    out_ready = ordy;
    @(negedge clk);
    exp_ir = (fullq.size() < 2);
    exp_ov = (fullq.size() > 0);
    chk("in_ready", {255'd0, in_ready}, {255'd0, exp_ir});
    chk("out_valid", {255'd0, out_valid}, {255'd0, exp_ov});
    if (exp_ov) begin
      for (int i = 0; i < 8; i++) e[i*W +: W] = fullq[0][(i*8 + col_idx)*W +: W];
      chk("out_col", out_col, e);
      chk("out_last", {255'd0, out_last}, {255'd0, (col_idx == 7)});
    end else begin
      chk("out_last_idle", {255'd0, out_last}, '0);
    end
    rd = exp_ov && ordy;
    wr = iv && exp_ir;
    @(posedge clk);
    if (rd) begin
      col_idx++;
      if (col_idx == 8) begin
        void'(fullq.pop_front());
        col_idx = 0;
      end
    end
    if (wr) begin
      for (int c = 0; c < 8; c++) part[(part_rows*8 + c)*W +: W] = rowq[0][c*W +: W];
      void'(rowq.pop_front());
      part_rows++;
      if (part_rows == 8) begin
        fullq.push_back(part);
        part_rows = 0;
      end
    end
    #1;
  endtask

  task automatic run(input int n, input int ordy_mode, input int gap_pct);
    // ordy_mode: 0 low, 1 high, 2 toggling, 3 random
    logic o;
    for (int k = 0; k < n; k++) begin
      case (ordy_mode)
        0:       o = 1'b0;
        1:       o = 1'b1;
        2:       o = k[0];
        default: o = 1'($urandom_range(0, 1));
      endcase
      cycle(o, gap_pct);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {255'd0, in_ready},  {255'd0, 1'b1});
    chk({tag, "_out_valid"}, {255'd0, out_valid}, '0);
    chk({tag, "_out_last"},  {255'd0, out_last},  '0);
    chk({tag, "_out_col"},   out_col, '0);
  endtask

  initial begin
    logic [8*W-1:0]   r;
    logic [W16-1:0]   m16 [64];
    logic [8*W16-1:0] e16;

    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_row16 = '0; out_ready16 = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block, element c of row r = 8r+c
    for (int rr = 0; rr < 8; rr++) begin
      for (int c = 0; c < 8; c++) r[c*W +: W] = 32'(8*rr + c);
      rowq.push_back(r);
    end
    run(20, 1, 0);

    // Back-to-back blocks, no gaps
    push_rand_rows(16);
    run(30, 1, 0);

    // Backpressure: 17 rows with the reader stalled, then release
    push_rand_rows(17);
    run(24, 0, 0);
    run(40, 1, 0);

    // Stall stability with out_ready toggling
    push_rand_rows(16);
    run(70, 2, 0);

    // Random traffic
    push_rand_rows(48);
    run(250, 3, 30);
    run(40, 1, 0);

    // Reset after 5 rows of a block
    push_rand_rows(5);
    run(5, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_rand_rows(8);
    run(20, 1, 0);

    // 16-bit instance with boundary patterns
    for (int k = 0; k < 64; k++) m16[k] = 16'($urandom);
    m16[0*8 + 7] = 16'h8000;
    m16[7*8 + 0] = 16'hFFFF;
    m16[3*8 + 5] = 16'h7FFF;
    out_ready16 = 1'b1;
    for (int rr = 0; rr < 8; rr++) begin
      for (int c = 0; c < 8; c++) in_row16[c*W16 +: W16] = m16[rr*8 + c];
      in_valid16 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) e16[i*W16 +: W16] = m16[i*8 + k];
      chk("w16_valid", {255'd0, out_valid16}, {255'd0, 1'b1});
      chk("w16_col", {128'd0, out_col16}, {128'd0, e16});
      chk("w16_last", {255'd0, out_last16}, {255'd0, (k == 7)});
      if (k == 7) chk("w16_r0c7", {240'd0, out_col16[0*W16 +: W16]}, {240'd0, 16'h8000});
      if (k == 0) chk("w16_r7c0", {240'd0, out_col16[7*W16 +: W16]}, {240'd0, 16'hFFFF});
      if (k == 5) chk("w16_r3c5", {240'd0, out_col16[3*W16 +: W16]}, {240'd0, 16'h7FFF});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w16_drained", {255'd0, out_valid16}, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
